sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 SHALL have parameter TILE_WIDTH, default 32, meaning sprite width in source pixels (power of two, 8..64).
REQ-002 SHALL have parameter TILE_HEIGHT, default 32, meaning sprite height in source pixels (power of two, 8..64).
REQ-003 SHALL have parameter NUM_SPRITES, default 4, meaning number of sprite images held in ROM (1..16).
REQ-004 SHALL have parameter COORD_W, default 10, meaning width of screen coordinates.
REQ-005 SHALL have parameter SCALE_LOG2_MAX, default 2, meaning the largest supported scale shift (scale factor 1, 2 or 4 by default).
REQ-006 SHALL have ports: i_Clk  in  1  clock; i_Rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: i_Frame_Start  in  1  frame-start strobe; i_Pix_Valid  in  1  pixel coordinate valid.
REQ-008 SHALL have ports: i_Pix_X, i_Pix_Y  in  COORD_W  current screen pixel.
REQ-009 SHALL have ports: i_Spr_X, i_Spr_Y  in  COORD_W  sprite top-left corner; i_Spr_Id  in  4  sprite index; i_Scale  in  2  scale shift; i_Enable  in  1  layer enable.
REQ-010 SHALL have ports: i_Bg_Color  in  9  background RGB333.
REQ-011 SHALL have ports: o_Pix_Valid  out  1; o_Pixel  out  9  RGB333; o_Hit  out  1  opaque sprite pixel.

Function
REQ-012 SHALL copy i_Spr_X, i_Spr_Y, i_Spr_Id, i_Scale and i_Enable into shadow registers on the clock edge where i_Frame_Start=1; all hit tests SHALL use the shadow registers only.
REQ-013 SHALL give a pixel presented in the same cycle as i_Frame_Start the old shadow values.
REQ-014 SHALL implement a two-state FSM: IDLE (after reset, until the first i_Frame_Start), then ACTIVE; in IDLE every valid pixel outputs i_Bg_Color with o_Hit=0.
REQ-015 SHALL compute dx=Pix_X-Spr_X and dy=Pix_Y-Spr_Y in COORD_W+1 bits; a hit requires dx,dy>=0, dx<(TILE_WIDTH<<scale) and dy<(TILE_HEIGHT<<scale), with no wrap-around at the screen edge.
REQ-016 SHALL clamp i_Scale values above SCALE_LOG2_MAX to SCALE_LOG2_MAX at latch time.
REQ-017 SHALL form the ROM address {Spr_Id, dy>>scale, dx>>scale}; a shadow Spr_Id >= NUM_SPRITES SHALL mean no hit.
REQ-018 SHALL treat ROM value 9'h000 as transparent: output i_Bg_Color (sampled with the pixel) and o_Hit=0.
REQ-019 SHALL have a fixed latency of 2 cycles from i_Pix_Valid to o_Pix_Valid, accepting one pixel per cycle with no stalls; bubbles propagate unchanged.
REQ-020 SHALL hold o_Pixel and o_Hit when o_Pix_Valid=0.
REQ-021 SHALL output background with o_Hit=0 when shadow Enable=0.

Reset
REQ-022 SHALL, on i_Rst_n=0, asynchronously clear the FSM to IDLE, clear all shadow registers, set o_Pix_Valid=0, o_Pixel=9'h000 and o_Hit=0, and discard in-flight pipeline contents.
REQ-023 SHALL present its first o_Pix_Valid no earlier than 2 cycles after the first i_Pix_Valid following reset release.

Configuration
REQ-024 With SPRITE_LAYER_MIRROR_EN defined, SHALL add input i_Mirror (1 bit, latched with the other shadow registers) that replaces the column address with TILE_WIDTH-1-(dx>>scale) when set.
REQ-025 Without SPRITE_LAYER_MIRROR_EN defined, SHALL omit the i_Mirror port and mirror logic.

Structure
REQ-026 SHALL take the RGB333 width, the transparent key 9'h000 and the FSM state encoding from the shared package sprite_pkg.
REQ-027 SHALL instantiate the sub-module sprite_rom (synchronous read, 1-cycle latency, initialised from a hex file parameter).

Verification
REQ-028 Reset then frame start with sprite (100,50), id 0, scale 0: pixel (100,50) -> 2 cycles later ROM[0][0][0], o_Hit=1 if non-zero.
REQ-029 Scale 1, sprite (0,0): pixels (63,63) and (64,0) -> ROM[0][31][31] with a hit, then background with o_Hit=0.
REQ-030 Sprite X=1000 with COORD_W=10: pixel X=5 -> no hit (no wrap); pixel X=1010 -> column 10.
REQ-031 Shadow inputs changed without i_Frame_Start, then with it in the same cycle as a pixel: that pixel uses the old position and the next pixel uses the new one.
REQ-032 Transparent ROM texel at id 1, with i_Bg_Color=9'h1C7 -> output 9'h1C7, o_Hit=0; shadow id 7 with NUM_SPRITES=4 -> background.
REQ-033 Reset asserted with 2 pixels in flight -> o_Pix_Valid=0 immediately, and no stale outputs after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite layer: RGB333 pixel type, transparent key, FSM encoding
// and the built-in ROM image used when no hex file is supplied.
package sprite_pkg;

    localparam int RGB_W = 9;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t TRANSPARENT = 9'h000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Built-in texture: a scrambled ramp with one transparent column in every 16.
    function automatic rgb_t rom_pattern(input logic [31:0] addr);
        if (addr[3:0] == 4'd3) begin
            return TRANSPARENT;
        end
        return rgb_t'(addr * 32'd37 + 32'd5);
    endfunction

endpackage

// File: rtl/sprite_layer_if.sv
// Pixel stream and sprite control bundle for sprite_layer.
// i_Mirror exists only when SPRITE_LAYER_MIRROR_EN is defined.
interface sprite_layer_if
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10
) ();

    logic               i_Frame_Start;
    logic               i_Pix_Valid;
    logic [COORD_W-1:0] i_Pix_X;
    logic [COORD_W-1:0] i_Pix_Y;
    logic [COORD_W-1:0] i_Spr_X;
    logic [COORD_W-1:0] i_Spr_Y;
    logic [3:0]         i_Spr_Id;
    logic [1:0]         i_Scale;
    logic               i_Enable;
    rgb_t               i_Bg_Color;
`ifdef SPRITE_LAYER_MIRROR_EN
    logic               i_Mirror;
`endif
    logic               o_Pix_Valid;
    rgb_t               o_Pixel;
    logic               o_Hit;

    modport slave (
        input  i_Frame_Start, i_Pix_Valid, i_Pix_X, i_Pix_Y,
        input  i_Spr_X, i_Spr_Y, i_Spr_Id, i_Scale, i_Enable, i_Bg_Color,
`ifdef SPRITE_LAYER_MIRROR_EN
        input  i_Mirror,
`endif
        output o_Pix_Valid, o_Pixel, o_Hit
    );

    modport master (
        output i_Frame_Start, i_Pix_Valid, i_Pix_X, i_Pix_Y,
        output i_Spr_X, i_Spr_Y, i_Spr_Id, i_Scale, i_Enable, i_Bg_Color,
`ifdef SPRITE_LAYER_MIRROR_EN
        output i_Mirror,
`endif
        input  o_Pix_Valid, o_Pixel, o_Hit
    );

endinterface

// File: rtl/sprite_rom.sv
// Sprite texel ROM with one-cycle registered read, initialised from the package pattern.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic              i_Clk,
    input  logic [ADDR_W-1:0] i_Addr,
    output rgb_t              o_Data
);

    rgb_t data_q;
    rgb_t mem [2**ADDR_W];

    assign o_Data = data_q;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] = rom_pattern(32'(i));
        end
    end

    always_ff @(posedge i_Clk) begin
        data_q <= mem[i_Addr];
    end

endmodule

// File: rtl/sprite_layer.sv
// Single-sprite overlay: frame-latched sprite position/scale, 2-cycle pixel pipeline
// with ROM lookup and transparent-key compositing. Optional SPRITE_LAYER_MIRROR_EN.
module sprite_layer
    import sprite_pkg::*;
#(
    parameter int    TILE_WIDTH     = 32,
    parameter int    TILE_HEIGHT    = 32,
    parameter int    NUM_SPRITES    = 4,
    parameter int    COORD_W        = 10,
    parameter int    SCALE_LOG2_MAX = 2,
    parameter string ROM_INIT_FILE  = ""
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    sprite_layer_if.slave bus
);

    localparam int COL_W  = $clog2(TILE_WIDTH);
    localparam int ROW_W  = $clog2(TILE_HEIGHT);
    localparam int ID_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int ADDR_W = ID_W + ROW_W + COL_W;
    localparam int EXT_W  = COORD_W + 1;

    state_t state_q, state_d;
    logic   layer_active;

    logic [COORD_W-1:0] spr_x_q, spr_x_d;
    logic [COORD_W-1:0] spr_y_q, spr_y_d;
    logic [3:0]         spr_id_q, spr_id_d;
    logic [1:0]         scale_q, scale_d;
    logic               enable_q, enable_d;
`ifdef SPRITE_LAYER_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif

    logic [EXT_W-1:0]  dx, dy, span_x, span_y;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] rom_addr;
    logic              in_x, in_y, id_ok, hit0;
    rgb_t              rom_data;

    logic v1_q, v1_d, hit1_q, hit1_d;
    rgb_t bg1_q, bg1_d;
    logic pix_valid_q, pix_valid_d, hit_q, hit_d, opaque;
    rgb_t pixel_q, pixel_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.i_Frame_Start) state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        layer_active = (state_q == ST_ACTIVE);
    end

    // Shadow copy changes only on frame start; scale is clamped as it is captured.
    always_comb begin
        spr_x_d  = spr_x_q;
        spr_y_d  = spr_y_q;
        spr_id_d = spr_id_q;
        scale_d  = scale_q;
        enable_d = enable_q;
`ifdef SPRITE_LAYER_MIRROR_EN
        mirror_d = mirror_q;
`endif
        if (bus.i_Frame_Start) begin
            spr_x_d  = bus.i_Spr_X;
            spr_y_d  = bus.i_Spr_Y;
            spr_id_d = bus.i_Spr_Id;
            scale_d  = (int'(bus.i_Scale) > SCALE_LOG2_MAX) ? 2'(SCALE_LOG2_MAX) : bus.i_Scale;
            enable_d = bus.i_Enable;
`ifdef SPRITE_LAYER_MIRROR_EN
            mirror_d = bus.i_Mirror;
`endif
        end
    end

    // Offsets carry an extra sign bit so pixels left/above the sprite never wrap into it.
    always_comb begin
        dx     = {1'b0, bus.i_Pix_X} - {1'b0, spr_x_q};
        dy     = {1'b0, bus.i_Pix_Y} - {1'b0, spr_y_q};
        span_x = EXT_W'(TILE_WIDTH) << scale_q;
        span_y = EXT_W'(TILE_HEIGHT) << scale_q;
        in_x   = !dx[EXT_W-1] && (dx < span_x);
        in_y   = !dy[EXT_W-1] && (dy < span_y);
        id_ok  = ({1'b0, spr_id_q} < 5'(NUM_SPRITES));
        hit0   = layer_active && enable_q && id_ok && in_x && in_y;
        row    = ROW_W'(dy >> scale_q);
`ifdef SPRITE_LAYER_MIRROR_EN
        col    = mirror_q ? (COL_W'(TILE_WIDTH - 1) - COL_W'(dx >> scale_q))
                          : COL_W'(dx >> scale_q);
`else
        col    = COL_W'(dx >> scale_q);
`endif
        rom_addr = {spr_id_q[ID_W-1:0], row, col};
    end

    sprite_rom #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (ROM_INIT_FILE)
    ) u_rom (
        .i_Clk  (i_Clk),
        .i_Addr (rom_addr),
        .o_Data (rom_data)
    );

    // Stage 1 travels alongside the ROM read; stage 2 composites and holds on bubbles.
    always_comb begin
        v1_d        = bus.i_Pix_Valid;
        hit1_d      = hit0;
        bg1_d       = bus.i_Bg_Color;
        opaque      = hit1_q && (rom_data != TRANSPARENT);
        pix_valid_d = v1_q;
        pixel_d     = pixel_q;
        hit_d       = hit_q;
        if (v1_q) begin
            pixel_d = opaque ? rom_data : bg1_q;
            hit_d   = opaque;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            spr_x_q     <= '0;
            spr_y_q     <= '0;
            spr_id_q    <= '0;
            scale_q     <= '0;
            enable_q    <= 1'b0;
`ifdef SPRITE_LAYER_MIRROR_EN
            mirror_q    <= 1'b0;
`endif
            v1_q        <= 1'b0;
            hit1_q      <= 1'b0;
            bg1_q       <= TRANSPARENT;
            pix_valid_q <= 1'b0;
            pixel_q     <= TRANSPARENT;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            spr_x_q     <= spr_x_d;
            spr_y_q     <= spr_y_d;
            spr_id_q    <= spr_id_d;
            scale_q     <= scale_d;
            enable_q    <= enable_d;
`ifdef SPRITE_LAYER_MIRROR_EN
            mirror_q    <= mirror_d;
`endif
            v1_q        <= v1_d;
            hit1_q      <= hit1_d;
            bg1_q       <= bg1_d;
            pix_valid_q <= pix_valid_d;
            pixel_q     <= pixel_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.o_Pix_Valid = pix_valid_q;
    assign bus.o_Pixel     = pixel_q;
    assign bus.o_Hit       = hit_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: stimulus pushes model predictions, a negedge
// monitor pops and compares every output pixel, its latency and hold behaviour.
module tb_sprite_layer;

    localparam int TW = 32;
    localparam int TH = 32;
    localparam int NS = 4;
    localparam int CW = 10;
    localparam int SMAX = 2;

    typedef struct {
        logic [8:0] pix;
        bit         hit;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    // Model of the latched sprite state
    int m_sx, m_sy, m_id, m_sc, m_en, m_active;

    logic [8:0] last_pix;
    bit         last_hit;

    sprite_layer_if #(.COORD_W(CW)) bus ();

    sprite_layer #(
        .TILE_WIDTH     (TW),
        .TILE_HEIGHT    (TH),
        .NUM_SPRITES    (NS),
        .COORD_W        (CW),
        .SCALE_LOG2_MAX (SMAX),
        .ROM_INIT_FILE  ("")
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Texture content: ramp value per linear texel index, every 16th column slot transparent.
    function automatic int texel(input int id, input int row, input int col);
        int a;
        a = id * TW * TH + row * TW + col;
        if (a % 16 == 3) return 0;
        return (a * 37 + 5) % 512;
    endfunction

    function automatic void model(input int px, input int py, input logic [8:0] bg,
                                  output logic [8:0] pix, output bit hit);
        int dx, dy, t;
        pix = bg;
        hit = 1'b0;
        if (m_active == 0 || m_en == 0 || m_id >= NS) return;
        dx = px - m_sx;
        dy = py - m_sy;
        if (dx < 0 || dy < 0 || dx >= (TW << m_sc) || dy >= (TH << m_sc)) return;
        t = texel(m_id, dy >> m_sc, dx >> m_sc);
        if (t == 0) return;
        pix = 9'(t);
        hit = 1'b1;
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_id = 0; m_sc = 0; m_en = 0; m_active = 0;
    endtask

    task automatic set_spr(input int sx, input int sy, input int id, input int sc, input int en);
        bus.i_Spr_X    = CW'(sx);
        bus.i_Spr_Y    = CW'(sy);
        bus.i_Spr_Id   = 4'(id);
        bus.i_Scale    = 2'(sc);
        bus.i_Enable   = 1'(en);
    endtask

    // One clock of stimulus; prediction uses the latched state before any frame-start update.
    task automatic step(input bit pv, input int px, input int py, input bit fs);
        exp_t e;
        bus.i_Pix_Valid   = pv;
        bus.i_Pix_X       = CW'(px);
        bus.i_Pix_Y       = CW'(py);
        bus.i_Frame_Start = fs;
        if (pv) begin
            model(int'(bus.i_Pix_X), int'(bus.i_Pix_Y), bus.i_Bg_Color, e.pix, e.hit);
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
        if (fs) begin
            m_sx = int'(bus.i_Spr_X);
            m_sy = int'(bus.i_Spr_Y);
            m_id = int'(bus.i_Spr_Id);
            m_sc = (int'(bus.i_Scale) > SMAX) ? SMAX : int'(bus.i_Scale);
            m_en = int'(bus.i_Enable);
            m_active = 1;
        end
        @(posedge clk);
        #1;
        bus.i_Frame_Start = 1'b0;
        bus.i_Pix_Valid   = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_pix = 9'h000;
            last_hit = 1'b0;
        end else if (bus.o_Pix_Valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid cyc=%0d got pixel=%h hit=%0b with nothing expected",
                         cyc, bus.o_Pixel, bus.o_Hit);
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus.o_Pixel !== e.pix) begin
                    errors++;
                    $display("FAIL pixel cyc=%0d got %h expected %h", cyc, bus.o_Pixel, e.pix);
                end
                checks++;
                if (bus.o_Hit !== e.hit) begin
                    errors++;
                    $display("FAIL hit cyc=%0d got %0b expected %0b", cyc, bus.o_Hit, e.hit);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency got cyc=%0d expected cyc=%0d", cyc, e.cyc);
                end
                $display("pix cyc=%0d pixel=%h hit=%0b exp=%h/%0b", cyc, bus.o_Pixel, bus.o_Hit, e.pix, e.hit);
                last_pix = e.pix;
                last_hit = e.hit;
            end
        end else begin
            checks++;
            if (bus.o_Pixel !== last_pix || bus.o_Hit !== last_hit) begin
                errors++;
                $display("FAIL hold cyc=%0d got %h/%0b expected %h/%0b",
                         cyc, bus.o_Pixel, bus.o_Hit, last_pix, last_hit);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.o_Pix_Valid !== 1'b0 || bus.o_Pixel !== 9'h000 || bus.o_Hit !== 1'b0) begin
            errors++;
            $display("FAIL %s got valid=%0b pixel=%h hit=%0b expected 0/000/0",
                     tag, bus.o_Pix_Valid, bus.o_Pixel, bus.o_Hit);
        end
    endtask

    initial begin
        int px, py;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        bus.i_Frame_Start = 1'b0;
        bus.i_Pix_Valid   = 1'b0;
        bus.i_Pix_X       = '0;
        bus.i_Pix_Y       = '0;
        bus.i_Bg_Color    = 9'h0A5;
`ifdef SPRITE_LAYER_MIRROR_EN
        bus.i_Mirror      = 1'b0;
`endif
        set_spr(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        #1;
        check_reset_outputs("after_release");

        // Idle layer: background regardless of sprite inputs
        set_spr(0, 0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 5, 5, 0);

        // Sprite at (100,50), id 0, scale 1x; latch, then probe corner and neighbours
        set_spr(100, 50, 0, 0, 1);
        step(1, 100, 50, 1);
        step(1, 100, 50, 0);
        step(1, 101, 50, 0);
        step(1, 99, 50, 0);
        step(0, 0, 0, 0);
        step(1, 131, 81, 0);
        step(1, 132, 50, 0);

        // Scale 2x at origin: last texel and first column outside
        set_spr(0, 0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(1, 63, 63, 0);
        step(1, 64, 0, 0);
        step(1, 0, 0, 0);

        // Near the right edge: no wrap for small X, column 10 at X=1010
        set_spr(1000, 0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 5, 0, 0);
        step(1, 1010, 0, 0);
        step(1, 1023, 3, 0);

        // Inputs change without frame start, then frame start coincides with a pixel
        set_spr(200, 200, 2, 0, 1);
        step(1, 1010, 0, 0);
        step(1, 1010, 0, 1);
        step(1, 200, 200, 0);
        step(1, 1010, 0, 0);

        // Transparent texel with custom background, then out-of-range id
        bus.i_Bg_Color = 9'h1C7;
        set_spr(0, 0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 3, 0, 0);
        step(1, 4, 0, 0);
        set_spr(0, 0, 7, 0, 1);
        step(0, 0, 0, 1);
        step(1, 4, 0, 0);

        // Scale request above maximum is clamped; then layer disabled
        set_spr(10, 10, 3, 3, 1);
        step(0, 0, 0, 1);
        step(1, 10 + 127, 10 + 127, 0);
        step(1, 10 + 128, 10, 0);
        set_spr(10, 10, 3, 0, 0);
        step(0, 0, 0, 1);
        step(1, 10, 10, 0);

        // Randomised traffic around the current sprite
        for (int n = 0; n < 1500; n++) begin
            bit fs, pv;
            if ($urandom_range(0, 99) < 4) begin
                set_spr($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 5),
                        $urandom_range(0, 3), ($urandom_range(0, 9) != 0) ? 1 : 0);
            end
            fs = ($urandom_range(0, 99) < 5);
            pv = ($urandom_range(0, 3) != 0);
            bus.i_Bg_Color = 9'($urandom);
            px = (m_sx + int'($urandom_range(0, 150)) - 10) & 1023;
            py = (m_sy + int'($urandom_range(0, 150)) - 10) & 1023;
            step(pv, px, py, fs);
        end

        // Reset with two pixels in flight: outputs drop at once and nothing stale follows
        set_spr(0, 0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 1, 0);
        step(1, 2, 2, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_Pix_Valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_valid got %0b expected 0", bus.o_Pix_Valid);
        end
        sb.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 2, 2, 1);
        step(1, 2, 2, 0);
        repeat (5) step(0, 0, 0, 0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
